// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the merged polar-SC PE array.
// LLRs are sign-magnitude: MSB is the sign, the remaining bits are the magnitude.
package pe_pkg;

    // Default LLR width, used by the sign-magnitude struct below.
    localparam int LLR_W = 9;

    // Width of the optional saturation-event counter (SAT_STATS_EN builds).
    localparam int SAT_CNT_W = 16;

    // Field view of a default-width LLR.
    typedef struct packed {
        logic                 sign;
        logic [LLR_W-2:0]     mag;
    } llr_sm_t;

    // Largest representable magnitude for a w-bit sign-magnitude LLR.
    function automatic int llr_mag_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Sign-magnitude to two's complement; -0 maps to 0.
    function automatic int sm_to_2c(input logic [31:0] sm, input int w);
        int mag;
        mag = int'(sm & 32'(llr_mag_max(w)));
        if (((sm >> (w - 1)) & 32'd1) != 32'd0) begin
            return -mag;
        end
        return mag;
    endfunction

    // Two's complement to sign-magnitude, clamping the magnitude to the
    // largest representable value. A zero result is always +0.
    function automatic logic [31:0] tc_to_sm_sat(input int v, input int w);
        int          mag;
        logic [31:0] res;
        mag = (v < 0) ? -v : v;
        if (mag > llr_mag_max(w)) begin
            mag = llr_mag_max(w);
        end
        if (mag == 0) begin
            res = '0;
        end else begin
            res = 32'(mag) | ((v < 0) ? (32'd1 << (w - 1)) : 32'd0);
        end
        return res;
    endfunction

    // True when a two's-complement result exceeds the representable magnitude.
    function automatic logic is_sat(input int v, input int w);
        return (v > llr_mag_max(w)) || (v < -llr_mag_max(w));
    endfunction

endpackage

// File: rtl/merged_pe_lane.sv
// One lane of the merged PE: two register stages, no handshake logic.
// Stage 1 captures the f sign, min magnitude and raw b+a / b-a sums (W+1 bits);
// stage 2 saturates, converts back to sign-magnitude and selects g by beta.
module merged_pe_lane
    import pe_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s1_en,
    input  logic         s2_en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         beta,
    output logic [W-1:0] f,
    output logic [W-1:0] g0,
    output logic [W-1:0] g1,
    output logic [W-1:0] gsel,
    output logic         sat
);

    logic signed [W:0] a_tc;
    logic signed [W:0] b_tc;
    logic [W-2:0]      min_mag;

    logic              s1_sign_f;
    logic [W-2:0]      s1_min;
    logic signed [W:0] s1_sum0;
    logic signed [W:0] s1_sum1;
    logic              s1_beta;

    logic [W-1:0]      f_d;
    logic [W-1:0]      g0_d;
    logic [W-1:0]      g1_d;
    logic [W-1:0]      gsel_d;
    logic              sat_d;

    // W+1 bits hold any sum or difference of two W-bit SM values without overflow.
    assign a_tc    = (W+1)'(sm_to_2c(32'(a), W));
    assign b_tc    = (W+1)'(sm_to_2c(32'(b), W));
    assign min_mag = (a[W-2:0] < b[W-2:0]) ? a[W-2:0] : b[W-2:0];

    // Stage 1 register: signs folded into the f sign, min magnitude, raw g sums.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: data registers are reset too (not just valids) because the outputs
    // must read all-zero while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign_f <= 1'b0;
            s1_min    <= '0;
            s1_sum0   <= '0;
            s1_sum1   <= '0;
            s1_beta   <= 1'b0;
        end else if (s1_en) begin
            s1_sign_f <= a[W-1] ^ b[W-1];
            s1_min    <= min_mag;
            s1_sum0   <= b_tc + a_tc;
            s1_sum1   <= b_tc - a_tc;
            s1_beta   <= beta;
        end
    end

    // Stage 2 combinational: saturate, back to sign-magnitude, normalise -0, select g.
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which is what keeps always_comb from inferring a latch.
    always_comb begin
        f_d    = '0;
        g0_d   = '0;
        g1_d   = '0;
        gsel_d = '0;
        sat_d  = 1'b0;
        if (s1_min != '0) begin
            f_d = {s1_sign_f, s1_min};
        end
        g0_d   = W'(tc_to_sm_sat(int'(s1_sum0), W));
        g1_d   = W'(tc_to_sm_sat(int'(s1_sum1), W));
        gsel_d = s1_beta ? g1_d : g0_d;
        sat_d  = is_sat(int'(s1_sum0), W) || is_sat(int'(s1_sum1), W);
    end

    // Stage 2 register: final per-lane results held until the beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f    <= '0;
            g0   <= '0;
            g1   <= '0;
            gsel <= '0;
            sat  <= 1'b0;
        end else if (s2_en) begin
            f    <= f_d;
            g0   <= g0_d;
            g1   <= g1_d;
            gsel <= gsel_d;
            sat  <= sat_d;
        end
    end

endmodule

// File: rtl/merged_pe_array.sv
// Pipelined array of LANES merged polar-SC PEs with valid/ready on both sides.
// Two register stages, latency 2, one beat per cycle; in_ready is combinational
// from out_ready (no skid buffer). flush drops all in-flight beats.
// Optional feature: define SAT_STATS_EN to add the sat_count saturation counter.
module merged_pe_array
    import pe_pkg::*;
#(
    parameter int LANES = 4,
    parameter int W     = 9,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    input  logic [LANES-1:0]     in_beta,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_f,
    output logic [LANES*W-1:0]   out_g0,
    output logic [LANES*W-1:0]   out_g1,
    output logic [LANES*W-1:0]   out_gsel,
`ifdef SAT_STATS_EN
    output logic [TAG_W-1:0]     out_tag,
    output logic [SAT_CNT_W-1:0] sat_count
`else
    output logic [TAG_W-1:0]     out_tag
`endif
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic             s1_en;
    logic             s2_en;
    logic [TAG_W-1:0] s1_tag;
    logic [LANES-1:0] lane_sat;

    // Each stage moves when it is empty or the stage after it is moving.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Data registers load only on a real transfer, and never during flush.
    assign s1_en = in_valid && s1_adv && !flush;
    assign s2_en = s1_valid && s2_adv && !flush;

    // Stage valids; flush wins over any advance on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Tag sideband follows the data through both stages unmodified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tag  <= '0;
            out_tag <= '0;
        end else begin
            if (s1_en) begin
                s1_tag <= in_tag;
            end
            if (s2_en) begin
                out_tag <= s1_tag;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        merged_pe_lane #(
            .W (W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .s1_en (s1_en),
            .s2_en (s2_en),
            .a     (in_a[i*W +: W]),
            .b     (in_b[i*W +: W]),
            .beta  (in_beta[i]),
            .f     (out_f[i*W +: W]),
            .g0    (out_g0[i*W +: W]),
            .g1    (out_g1[i*W +: W]),
            .gsel  (out_gsel[i*W +: W]),
            .sat   (lane_sat[i])
        );
    end

`ifdef SAT_STATS_EN
    logic [SAT_CNT_W-1:0] sat_lanes;
    logic [SAT_CNT_W:0]   sat_sum;

    // Number of lanes in the output beat whose g0 or g1 clamped.
    always_comb begin
        sat_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_lanes = sat_lanes + SAT_CNT_W'(lane_sat[i]);
        end
        sat_sum = {1'b0, sat_count} + {1'b0, sat_lanes};
    end

    // Saturating event counter, advanced on each output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (flush) begin
            sat_count <= '0;
        end else if (s2_valid && out_ready) begin
            sat_count <= sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
        end
    end
`else
    logic unused_lane_sat;
    assign unused_lane_sat = ^lane_sat;
`endif

endmodule

// File: tb/tb_merged_pe_array.sv
// Self-checking bench for merged_pe_array (LANES=4, W=9, TAG_W=8).
// Fixed vectors from a table, hand-written flush/reset sequences, and
// randomized streams checked against an arithmetic reference model.
module tb_merged_pe_array;

    localparam int LANES = 4;
    localparam int W     = 9;
    localparam int TAG_W = 8;
    localparam int BW    = LANES * W;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [BW-1:0]    in_a;
    logic [BW-1:0]    in_b;
    logic [LANES-1:0] in_beta;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [BW-1:0]    out_f;
    logic [BW-1:0]    out_g0;
    logic [BW-1:0]    out_g1;
    logic [BW-1:0]    out_gsel;
    logic [TAG_W-1:0] out_tag;
`ifdef SAT_STATS_EN
    logic [15:0]      sat_count;
`endif

    merged_pe_array #(
        .LANES (LANES),
        .W     (W),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_beta   (in_beta),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_g0    (out_g0),
        .out_g1    (out_g1),
        .out_gsel  (out_gsel),
`ifdef SAT_STATS_EN
        .out_tag   (out_tag),
        .sat_count (sat_count)
`else
        .out_tag   (out_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_sat  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------------
    typedef struct packed {
        logic [8:0] f;
        logic [8:0] g0;
        logic [8:0] g1;
        logic [8:0] gsel;
        logic       sat;
    } lane_res_t;

    typedef struct {
        logic [BW-1:0]    f;
        logic [BW-1:0]    g0;
        logic [BW-1:0]    g1;
        logic [BW-1:0]    gsel;
        logic [TAG_W-1:0] tag;
        int               nsat;
    } beat_t;

    beat_t sb[$];

    function automatic int sm_val(input logic [8:0] x);
        int m;
        m = int'(x[7:0]);
        return x[8] ? -m : m;
    endfunction

    function automatic logic [8:0] enc(input int v);
        int m;
        m = (v < 0) ? -v : v;
        if (m > 255) m = 255;
        if (m == 0) return 9'h000;
        return {(v < 0), 8'(m)};
    endfunction

    function automatic lane_res_t model(input logic [8:0] a, input logic [8:0] b, input logic beta);
        lane_res_t r;
        int av, bv, ma, mb, mn;
        av = sm_val(a);
        bv = sm_val(b);
        ma = (av < 0) ? -av : av;
        mb = (bv < 0) ? -bv : bv;
        mn = (ma < mb) ? ma : mb;
        r.f    = (mn == 0) ? 9'h000 : {a[8] ^ b[8], 8'(mn)};
        r.g0   = enc(bv + av);
        r.g1   = enc(bv - av);
        r.gsel = beta ? r.g1 : r.g0;
        r.sat  = (bv + av > 255) || (bv + av < -255) || (bv - av > 255) || (bv - av < -255);
        return r;
    endfunction

    function automatic beat_t expect_beat(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                          input logic [LANES-1:0] beta, input logic [TAG_W-1:0] tag);
        beat_t     r;
        lane_res_t l;
        r.f = '0; r.g0 = '0; r.g1 = '0; r.gsel = '0;
        r.tag  = tag;
        r.nsat = 0;
        for (int i = 0; i < LANES; i++) begin
            l = model(a[i*W +: W], b[i*W +: W], beta[i]);
            r.f[i*W +: W]    = l.f;
            r.g0[i*W +: W]   = l.g0;
            r.g1[i*W +: W]   = l.g1;
            r.gsel[i*W +: W] = l.gsel;
            r.nsat += int'(l.sat);
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 7))
                0:       v[i*W +: W] = 9'h100;
                1:       v[i*W +: W] = {1'($urandom_range(0, 1)), 8'hFF};
                default: v[i*W +: W] = 9'($urandom_range(0, 511));
            endcase
        end
        return v;
    endfunction

    task automatic check_beat(input string name, input beat_t e);
        check({name, "_tag"},  64'(out_tag),  64'(e.tag));
        check({name, "_f"},    64'(out_f),    64'(e.f));
        check({name, "_g0"},   64'(out_g0),   64'(e.g0));
        check({name, "_g1"},   64'(out_g1),   64'(e.g1));
        check({name, "_gsel"}, 64'(out_gsel), 64'(e.gsel));
    endtask

    task automatic check_sat(input string name);
`ifdef SAT_STATS_EN
        check(name, 64'(sat_count), 64'(exp_sat));
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // ---------------- streaming with scoreboard ----------------
    task automatic run_stream(input int n, input bit toggle, input int budget, input logic [TAG_W-1:0] tag0);
        int            sent, got, cyc;
        bit            prev_stall;
        beat_t         prev, e;
        logic [BW-1:0] a, b;
        logic [LANES-1:0] bt;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0;
        prev.f = '0; prev.g0 = '0; prev.g1 = '0; prev.gsel = '0; prev.tag = '0; prev.nsat = 0;
        while (got < n && cyc < budget) begin
            @(posedge clk); #1;
            out_ready = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            in_valid  = (sent < n) && (toggle || ($urandom_range(0, 2) != 0));
            a  = rand_bus();
            b  = rand_bus();
            bt = LANES'($urandom_range(0, 15));
            in_a = a; in_b = b; in_beta = bt; in_tag = tag0 + TAG_W'(sent);
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_tag",   64'(out_tag),   64'(prev.tag));
                check("stall_f",     64'(out_f),     64'(prev.f));
                check("stall_g0",    64'(out_g0),    64'(prev.g0));
                check("stall_g1",    64'(out_g1),    64'(prev.g1));
                check("stall_gsel",  64'(out_gsel),  64'(prev.gsel));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_beat("stream", e);
                    exp_sat = (exp_sat + e.nsat > 65535) ? 65535 : exp_sat + e.nsat;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(expect_beat(a, b, bt, tag0 + TAG_W'(sent)));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev.f = out_f; prev.g0 = out_g0; prev.g1 = out_g1; prev.gsel = out_gsel; prev.tag = out_tag;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stream_count", 64'(got), 64'(n));
        check("stream_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // ---------------- fixed vectors ----------------
    typedef struct {
        string            name;
        logic [8:0]       a;
        logic [8:0]       b;
        logic [LANES-1:0] beta;
        logic [8:0]       f;
        logic [8:0]       g0;
        logic [8:0]       g1;
        logic [BW-1:0]    gsel;
    } vec_t;

    vec_t  vecs[7];
    beat_t e;
    logic [BW-1:0] da, db;

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_beta = '0; in_tag = '0;

        vecs[0] = '{"v_basic_b0", 9'h08C, 9'h151, 4'b0000, 9'h151, 9'h03B, 9'h1DD, {4{9'h03B}}};
        vecs[1] = '{"v_basic_b1", 9'h08C, 9'h151, 4'b1111, 9'h151, 9'h03B, 9'h1DD, {4{9'h1DD}}};
        vecs[2] = '{"v_basic_mix", 9'h08C, 9'h151, 4'b1010, 9'h151, 9'h03B, 9'h1DD,
                    {9'h1DD, 9'h03B, 9'h1DD, 9'h03B}};
        vecs[3] = '{"v_pos_sat", 9'h0C8, 9'h0C8, 4'b0000, 9'h0C8, 9'h0FF, 9'h000, {4{9'h0FF}}};
        vecs[4] = '{"v_neg_zero", 9'h100, 9'h005, 4'b1111, 9'h000, 9'h005, 9'h005, {4{9'h005}}};
        vecs[5] = '{"v_neg_sat", 9'h1FF, 9'h1FF, 4'b0000, 9'h0FF, 9'h1FF, 9'h000, {4{9'h1FF}}};
        vecs[6] = '{"v_sub_sat", 9'h0FF, 9'h1FF, 4'b1111, 9'h1FF, 9'h000, 9'h1FF, {4{9'h1FF}}};

        // Reset state, sampled while reset is held and again after release.
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_f",     64'(out_f),     64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        #10;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_g0",    64'(out_g0),    64'd0);
        check_sat("post_rst_sat");

        // Table vectors: one beat each, latency exactly 2 cycles.
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_a      = {LANES{vecs[k].a}};
            in_b      = {LANES{vecs[k].b}};
            in_beta   = vecs[k].beta;
            in_tag    = TAG_W'(8'h40 + k);
            @(negedge clk);
            check({vecs[k].name, "_in_ready"}, 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check({vecs[k].name, "_lat1_valid"}, 64'(out_valid), 64'd0);
            @(negedge clk);
            check({vecs[k].name, "_valid"}, 64'(out_valid), 64'd1);
            check({vecs[k].name, "_tag"},   64'(out_tag),   64'(8'h40 + k));
            check({vecs[k].name, "_f"},     64'(out_f),     64'({LANES{vecs[k].f}}));
            check({vecs[k].name, "_g0"},    64'(out_g0),    64'({LANES{vecs[k].g0}}));
            check({vecs[k].name, "_g1"},    64'(out_g1),    64'({LANES{vecs[k].g1}}));
            check({vecs[k].name, "_gsel"},  64'(out_gsel),  64'(vecs[k].gsel));
            e = expect_beat({LANES{vecs[k].a}}, {LANES{vecs[k].b}}, vecs[k].beta, '0);
            exp_sat += e.nsat;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("tbl_drained", 64'(out_valid), 64'd0);
        check_sat("tbl_sat_count");

        // Eight tagged beats with out_ready toggling 1010...
        run_stream(8, 1'b1, 200, 8'h00);

        // Flush with a full, stalled pipe.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = rand_bus(); in_b = rand_bus(); in_beta = '0; in_tag = 8'hA0;
        @(negedge clk);
        check("fl_accept_a", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_a = rand_bus(); in_b = rand_bus(); in_tag = 8'hB0;
        @(negedge clk);
        check("fl_accept_b", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_a = rand_bus(); in_b = rand_bus(); in_tag = 8'hC0;
        flush = 1'b1;
        @(negedge clk);
        check("fl_full_in_ready", 64'(in_ready),  64'd0);
        check("fl_full_valid",    64'(out_valid), 64'd1);
        check("fl_full_tag",      64'(out_tag),   64'hA0);
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1; exp_sat = 0;
        da = rand_bus(); db = rand_bus();
        in_valid = 1'b1; in_a = da; in_b = db; in_beta = 4'b0110; in_tag = 8'hD0;
        @(negedge clk);
        check("fl_after_valid",    64'(out_valid), 64'd0);
        check("fl_after_in_ready", 64'(in_ready),  64'd1);
        check_sat("fl_sat_cleared");
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_d_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("fl_d_valid", 64'(out_valid), 64'd1);
        e = expect_beat(da, db, 4'b0110, 8'hD0);
        check_beat("fl_d", e);
        exp_sat += e.nsat;

        // Beat offered together with flush is discarded even though in_ready is high.
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = rand_bus(); in_b = rand_bus(); in_tag = 8'hE0; flush = 1'b1;
        @(negedge clk);
        check("fl2_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; exp_sat = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fl2_dropped", 64'(out_valid), 64'd0);
        end
        check_sat("fl2_sat");

        // Asynchronous reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_a = rand_bus(); in_b = rand_bus(); in_tag = 8'h11;
        @(posedge clk); #1;
        in_tag = 8'h12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("ar_full_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid",    64'(out_valid), 64'd0);
        check("ar_in_ready", 64'(in_ready),  64'd1);
        check("ar_f",        64'(out_f),     64'd0);
        check("ar_g0",       64'(out_g0),    64'd0);
        check("ar_g1",       64'(out_g1),    64'd0);
        check("ar_gsel",     64'(out_gsel),  64'd0);
        check("ar_tag",      64'(out_tag),   64'd0);
        exp_sat = 0;
        check_sat("ar_sat");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("ar_lost", 64'(out_valid), 64'd0);

        // Randomized valid/ready stream.
        run_stream(150, 1'b0, 3000, 8'h80);
        @(negedge clk);
        check_sat("rand_sat_count");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
